mem_bus2_responder: RTL and testbench
=====================================

Name: mem_bus2_responder

Overview:
- Memory-side responder on bus 2, the line-transfer link between the cache and main memory.
- Accepts line-granular C2_READ_LINE and C2_WRITE_LINE commands from the cache.
- Stores lines in an internal byte array and answers with C2_RESPONSE after a fixed latency.
- Read data returns as a multi-beat little-endian burst on D2; bus tristating is done at the top level from the *_OE outputs.

Parameters:
- LINE_ADDR_W, 15, line address width on A2 (tag + set bits).
- DATA2_W, 16, D2 width in bits; must be a multiple of 8.
- LINE_BYTES, 16, bytes per cache line.
- MEM_LATENCY, 100, cycles from command-sample edge to the first C2_RESPONSE edge; must be >= LINE_BEATS+1.
- Derived, not overridable: LINE_BEATS = LINE_BYTES*8/DATA2_W.

Ports:
- CLK  in  1  clock; all sampling and driving on posedge.
- RESET  in  1  asynchronous, active-low reset.
- A2_IN  in  LINE_ADDR_W  line address, valid in the command cycle.
- C2_IN  in  2  bus-2 command from the cache.
- D2_IN  in  DATA2_W  write-beat data.
- C2_OUT  out  2  responder command.
- C2_OE  out  1  responder owns C2.
- D2_OUT  out  DATA2_W  read-beat data.
- D2_OE  out  1  responder owns D2.

Behaviour:
- Encodings: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- Reset (RESET low, asynchronous): state=IDLE; C2_OUT=C2_NOP; C2_OE=0; D2_OE=0; D2_OUT=0; counters cleared.
- Reset does not clear the memory array. Power-up contents are undefined.
- Reset asserted mid-transfer aborts the transfer. A partially received write keeps the bytes already stored.

States:
- IDLE: sample C2_IN every edge.
  - READ_LINE: latch A2_IN → WAIT_RD; latency counter=1.
  - WRITE_LINE: latch A2_IN, store beat 0 from D2_IN → WR_RECV; beat counter=1, latency counter=1.
  - NOP or RESPONSE: stay in IDLE.
- WR_RECV: store one beat per edge. After beat LINE_BEATS-1 → WAIT_WR. The latency counter keeps running.
- WAIT_RD / WAIT_WR: latency counter increments each edge.
  - At the edge where the count reaches MEM_LATENCY, drive outputs and move to RD_SEND or WR_ACK.
- RD_SEND: C2_OE=1, C2_OUT=C2_RESPONSE, D2_OE=1 for exactly LINE_BEATS cycles. A new beat is presented each edge.
  - At the following edge: C2_OE=0, D2_OE=0, C2_OUT=C2_NOP → IDLE.
- WR_ACK: C2_OE=1, C2_OUT=C2_RESPONSE for exactly one cycle, then release → IDLE.

Data layout:
- Beat k carries line bytes k*DATA2_W/8 .. k*DATA2_W/8+DATA2_W/8-1.
- The lowest-numbered byte is on D2[7:0] (little-endian); the next is on D2[15:8].
- Byte address = {line address, byte index}. The address space is exactly 2^LINE_ADDR_W lines, so no wrap handling is needed.

Boundary conditions:
- Commands on C2_IN outside IDLE are ignored. The initiator must not issue them.
- Back-to-back operation: a command is accepted on the edge immediately after release, i.e. the first IDLE edge.
- A read of a line written earlier returns the last written data.

Optional Feature:
- Macro MEM_STATS_EN adds two outputs, RD_COUNT and WR_COUNT, 16 bits each.
  - Each increments once per completed read or write, on the release edge.
  - Both saturate at 16'hFFFF and clear on reset.
- Without the macro the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package bus2_pkg holds:
  - The C2 command enum and its encodings.
  - Responder state enum.
  - Default widths: DATA2 width, line size, line-address width.
  - Byte-per-beat constant.
- Sub-module mem_line_array: byte-addressed storage with one beat-wide write port and one beat-wide read port, addressed by {line, beat}.
  - Synchronous write.
  - Combinational read, so D2_OUT is valid in the same cycle the beat index advances.

Test Plan:
- Write line 0x0001 with beats 0x1100, 0x3322, …, 0xFFEE → WR_ACK: C2_OUT=1 with C2_OE=1 for exactly one cycle, MEM_LATENCY edges after command; D2_OE stays 0.
- Read line 0x0001 → after MEM_LATENCY edges, 8 cycles of C2_OUT=1/D2_OE=1 with D2_OUT=0x1100, 0x3322, …, 0xFFEE in order, then both OE low.
- Write lines 0x0000 and 0x7FFF, then read both → each returns its own data; the extremes do not alias.
- Issue C2_READ_LINE during WAIT_WR → ignored. Only one WR_ACK is produced, and no read burst follows.
- Assert RESET low at beat 4 of a read burst → asynchronously C2_OE=0, D2_OE=0; the next READ_LINE of the same line returns the full original data.
- Back-to-back: a WRITE_LINE presented on the first IDLE edge after a read release is accepted. With MEM_STATS_EN: RD_COUNT=1, WR_COUNT=2 after the sequence write, read, write.

Source files
------------

// File: rtl/bus2_pkg.sv
// Bus-2 shared types: C2 command encodings, responder states, default sizes.
// Imported by the memory responder and its line array.
package bus2_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_RECV = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WAIT_WR = 3'd3,
        S_RD_SEND = 3'd4,
        S_WR_ACK  = 3'd5
    } resp_state_e;

    localparam int DATA2_W_DEF     = 16;
    localparam int LINE_BYTES_DEF  = 16;
    localparam int LINE_ADDR_W_DEF = 15;
    localparam int MEM_LATENCY_DEF = 100;
    localparam int BYTES_PER_BEAT  = DATA2_W_DEF / 8;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Byte-lane storage addressed by {line, beat}; one beat-wide write port
// (synchronous) and one beat-wide combinational read port. No reset.
module mem_line_array
    import bus2_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W_DEF + 3,
    parameter int BPB    = BYTES_PER_BEAT
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [BPB*8-1:0]     wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [BPB*8-1:0]     rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH][BPB];

    for (genvar g = 0; g < BPB; g++) begin : g_lane
        // Store byte lane g of the beat; lane 0 is the lowest line byte.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr][g] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = mem[raddr][g];
    end

endmodule

// File: rtl/mem_bus2_responder.sv
// Bus-2 main-memory responder: line reads/writes with fixed latency.
// Optional macro MEM_STATS_EN adds saturating RD_COUNT/WR_COUNT outputs.
module mem_bus2_responder
    import bus2_pkg::*;
#(
    parameter int LINE_ADDR_W = LINE_ADDR_W_DEF,
    parameter int DATA2_W     = DATA2_W_DEF,
    parameter int LINE_BYTES  = LINE_BYTES_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [LINE_ADDR_W-1:0] A2_IN,
    input  logic [1:0]             C2_IN,
    input  logic [DATA2_W-1:0]     D2_IN,
    output logic [1:0]             C2_OUT,
    output logic                   C2_OE,
    output logic [DATA2_W-1:0]     D2_OUT,
    output logic                   D2_OE
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]            RD_COUNT,
    output logic [15:0]            WR_COUNT
`endif
);

    localparam int LINE_BEATS = LINE_BYTES * 8 / DATA2_W;
    localparam int BPB        = DATA2_W / 8;
    localparam int BEAT_W     = clog2_min1(LINE_BEATS);
    localparam int LAT_W      = clog2_min1(MEM_LATENCY + 1);
    localparam int ADDR_W     = LINE_ADDR_W + BEAT_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_DONE  = LAT_W'(MEM_LATENCY);

    resp_state_e            state;
    c2_cmd_e                c2_q;
    logic                   c2_oe_q;
    logic                   d2_oe_q;
    logic [LINE_ADDR_W-1:0] line_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [LAT_W-1:0]       lat_q;

    logic                   wr_cmd;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [ADDR_W-1:0]      raddr;
    logic [DATA2_W-1:0]     rdata;

    // Beat 0 lands on the command edge, later beats while in WR_RECV.
    always_comb begin
        wr_cmd = (state == S_IDLE) && (C2_IN == C2_WRITE_LINE);
        we     = RESET && (wr_cmd || (state == S_WR_RECV));
        waddr  = wr_cmd ? {A2_IN, BEAT_W'(0)} : {line_q, beat_q};
        raddr  = {line_q, beat_q};
    end

    mem_line_array #(
        .ADDR_W (ADDR_W),
        .BPB    (BPB)
    ) u_array (
        .clk   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (D2_IN),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign C2_OUT = c2_q;
    assign C2_OE  = c2_oe_q;
    assign D2_OE  = d2_oe_q;
    assign D2_OUT = d2_oe_q ? rdata : '0;

    // Command sequencer: accept, count latency, respond, release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            c2_q    <= C2_NOP;
            c2_oe_q <= 1'b0;
            d2_oe_q <= 1'b0;
            line_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    beat_q <= '0;
                    case (C2_IN)
                        C2_READ_LINE: begin
                            line_q <= A2_IN;
                            lat_q  <= LAT_W'(1);
                            state  <= S_WAIT_RD;
                        end
                        C2_WRITE_LINE: begin
                            line_q <= A2_IN;
                            lat_q  <= LAT_W'(1);
                            if (LINE_BEATS > 1) begin
                                beat_q <= BEAT_W'(1);
                                state  <= S_WR_RECV;
                            end else begin
                                state  <= S_WAIT_WR;
                            end
                        end
                        default: ;
                    endcase
                end
                S_WR_RECV: begin
                    lat_q <= lat_q + LAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_q <= '0;
                        state  <= S_WAIT_WR;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                S_WAIT_RD: begin
                    if (lat_q == LAT_DONE) begin
                        beat_q  <= '0;
                        c2_q    <= C2_RESPONSE;
                        c2_oe_q <= 1'b1;
                        d2_oe_q <= 1'b1;
                        state   <= S_RD_SEND;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_WAIT_WR: begin
                    if (lat_q == LAT_DONE) begin
                        c2_q    <= C2_RESPONSE;
                        c2_oe_q <= 1'b1;
                        state   <= S_WR_ACK;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_RD_SEND: begin
                    if (beat_q == LAST_BEAT) begin
                        beat_q  <= '0;
                        c2_q    <= C2_NOP;
                        c2_oe_q <= 1'b0;
                        d2_oe_q <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                S_WR_ACK: begin
                    c2_q    <= C2_NOP;
                    c2_oe_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    c2_q    <= C2_NOP;
                    c2_oe_q <= 1'b0;
                    d2_oe_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic rd_done;
    logic wr_done;

    assign rd_done = (state == S_RD_SEND) && (beat_q == LAST_BEAT);
    assign wr_done = (state == S_WR_ACK);

    // Completed-transfer counters, bumped on the release edge, saturating.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RD_COUNT <= '0;
            WR_COUNT <= '0;
        end else begin
            if (rd_done && (RD_COUNT != 16'hFFFF)) begin
                RD_COUNT <= RD_COUNT + 16'd1;
            end
            if (wr_done && (WR_COUNT != 16'hFFFF)) begin
                WR_COUNT <= WR_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus2_responder.sv
// Directed bench for mem_bus2_responder.
// Define MEM_STATS_EN to check counters.
module tb_mem_bus2_responder;

  localparam int L = 100;
  localparam int B = 8;

  logic        clk;
  logic        rst_n;
  logic [14:0] a2_in;
  logic [1:0]  c2_in;
  logic [15:0] d2_in;
  logic [1:0]  c2_out;
  logic        c2_oe;
  logic [15:0] d2_out;
  logic        d2_oe;
`ifdef MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] mdl [int];
  logic [15:0]  exp_q [$];

  function automatic void chk(
    input string tag,
    input bit    ok
  );
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s", tag);
    end
  endfunction

  mem_bus2_responder dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .A2_IN  (a2_in),
    .C2_IN  (c2_in),
    .D2_IN  (d2_in),
    .C2_OUT (c2_out),
    .C2_OE  (c2_oe),
    .D2_OUT (d2_out),
    .D2_OE  (d2_oe)
`ifdef MEM_STATS_EN
    ,
    .RD_COUNT (rd_count),
    .WR_COUNT (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(
    input int           line,
    input logic [127:0] data,
    input int           inject
  );
    bit early;
    early = 1'b0;
    mdl[line] = data;
    c2_in = 2'd3;
    a2_in = 15'(line);
    d2_in = data[15:0];
    for (int e = 0; e < L; e++) begin
      step();
      if (e == 0) begin
        c2_in = 2'd0;
        a2_in = '0;
      end
      if (e + 1 < B)
        d2_in = data[16*(e+1) +: 16];
      else
        d2_in = '0;
      if (inject > 0 && e == inject) begin
        c2_in = 2'd2;
        a2_in = 15'(line);
      end
      if (inject > 0 && e == inject + 1)
        c2_in = 2'd0;
      if (c2_oe || d2_oe) early = 1'b1;
    end
    chk("wr_quiet", early === 1'b0);
    step();
    chk("wr_ack",
        {c2_oe, c2_out, d2_oe} === 4'b1010);
    step();
    chk("wr_rel",
        {c2_oe, c2_out, d2_oe} === 4'b0000);
    if (inject > 0) begin
      early = 1'b0;
      for (int e = 0; e < L + B + 10; e++) begin
        step();
        if (c2_oe || d2_oe) early = 1'b1;
      end
      chk("ignored_read", early === 1'b0);
    end
  endtask

  task automatic do_read(
    input int line,
    input int rst_beat
  );
    bit early;
    logic [127:0] d;
    logic [15:0]  expd;
    early = 1'b0;
    d = mdl[line];
    for (int k = 0; k < B; k++)
      exp_q.push_back(d[16*k +: 16]);
    c2_in = 2'd2;
    a2_in = 15'(line);
    for (int e = 0; e < L; e++) begin
      step();
      if (e == 0) begin
        c2_in = 2'd0;
        a2_in = '0;
      end
      if (c2_oe || d2_oe) early = 1'b1;
    end
    chk("rd_quiet", early === 1'b0);
    for (int k = 0; k < B; k++) begin
      step();
      expd = exp_q.pop_front();
      chk("rd_ctl",
          {c2_oe, c2_out, d2_oe} === 4'b1011);
      chk("rd_data", d2_out === expd);
      if (k == rst_beat) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_c2oe", c2_oe === 1'b0);
        chk("rst_d2oe", d2_oe === 1'b0);
        chk("rst_d2out", d2_out === 16'h0000);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        return;
      end
    end
    step();
    chk("rd_rel",
        {c2_oe, c2_out, d2_oe} === 4'b0000);
  endtask

  initial begin
    logic [127:0] pat;
    rst_n = 1'b0;
    c2_in = 2'd0;
    a2_in = '0;
    d2_in = '0;
    step();
    step();
    chk("reset_c2out", c2_out === 2'd0);
    chk("reset_c2oe", c2_oe === 1'b0);
    chk("reset_d2oe", d2_oe === 1'b0);
    chk("reset_d2out", d2_out === 16'h0000);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < B; k++) begin
      pat[16*k +: 16] = {8'((2*k+1) * 8'h11),
                         8'((2*k) * 8'h11)};
    end
    do_write(1, pat, 0);
    do_read(1, -1);

    do_write(0, {$urandom, $urandom,
                 $urandom, $urandom}, 0);
    do_write(32'h7FFF, {$urandom, $urandom,
                        $urandom, $urandom}, 0);
    do_read(0, -1);
    do_read(32'h7FFF, -1);

    do_write(2, {$urandom, $urandom,
                 $urandom, $urandom}, 20);
    do_read(2, -1);

    do_read(1, 4);
`ifdef MEM_STATS_EN
    chk("stat_rst_rd", rd_count === 16'd0);
    chk("stat_rst_wr", wr_count === 16'd0);
`endif
    do_write(3, {$urandom, $urandom,
                 $urandom, $urandom}, 0);
    do_read(1, -1);
    do_write(4, {$urandom, $urandom,
                 $urandom, $urandom}, 0);
`ifdef MEM_STATS_EN
    chk("stat_rd", rd_count === 16'd1);
    chk("stat_wr", wr_count === 16'd2);
`endif
    do_read(4, -1);
    do_read(3, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
